// File: rtl/syncfifo_pro.sv
// syncfifo_pro: single-clock FIFO with optional registered first-word-fall-through output.
//
// Parameters
//   WID     data width
//   DEPTH   total word capacity (>= 2, any value; pointers wrap at DEPTH-1)
//   AWID    storage pointer width, $clog2(DEPTH)
//   OUTREG  0: dataout read combinationally from storage
//           1: dataout from an output register that counts as one of the DEPTH slots
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   softreset            synchronous flush, wins over same-cycle validin/readout
//   validin, datain      write request and data; full when no slot is free
//   readout, dataout     pop request and head-of-queue data; empty when nothing presentable
//   count                words held, including any word in the output register
//   afull_th, aempty_th  threshold inputs for afull (count >= th) and aempty (count <= th)
//   overflow, underflow  per-cycle pulses for rejected writes / reads
//   err_sticky, clr_err  sticky {underflow, overflow}; a new error wins over clr_err
module syncfifo_pro #(
  parameter int unsigned WID    = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AWID   = $clog2(DEPTH),
  parameter int unsigned OUTREG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            softreset,
  input  logic            validin,
  input  logic [WID-1:0]  datain,
  output logic            full,
  input  logic            readout,
  output logic [WID-1:0]  dataout,
  output logic            empty,
  output logic [AWID:0]   count,
  input  logic [AWID:0]   afull_th,
  input  logic [AWID:0]   aempty_th,
  output logic            afull,
  output logic            aempty,
  output logic            overflow,
  output logic            underflow,
  output logic [1:0]      err_sticky,
  input  logic            clr_err
);

  localparam int unsigned DepthM1 = DEPTH - 1;
  localparam logic [AWID:0]   CountMax = DEPTH[AWID:0];
  localparam logic [AWID-1:0] PtrLast  = DepthM1[AWID-1:0];

  logic [AWID-1:0] wptr_q, wptr_d;
  logic [AWID-1:0] rptr_q, rptr_d;
  logic [AWID:0]   count_q, count_d;
  logic [1:0]      err_q, err_d;
  logic [WID-1:0]  mem_q [DEPTH];

  logic wr_en;
  logic rd_en;
  logic stor_pop;  // head word leaves storage (to the reader or the output register)

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic logic [AWID-1:0] ptr_inc(input logic [AWID-1:0] p);
    return (p == PtrLast) ? '0 : p + AWID'(1);
  endfunction

  // full/empty are the pre-edge values, so a read never frees a slot for a same-cycle write.
  assign wr_en     = validin & ~full & ~softreset;
  assign rd_en     = readout & ~empty & ~softreset;
  assign full      = (count_q == CountMax);
  assign overflow  = validin & full;
  assign underflow = readout & empty;
  assign count     = count_q;
  assign afull     = (count_q >= afull_th);
  assign aempty    = (count_q <= aempty_th);
  assign err_sticky = err_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Set has priority over clear.
    err_d   = (clr_err ? 2'b00 : err_q) | {underflow, overflow};
    if (softreset) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      err_d   = 2'b00;
    end else begin
      if (wr_en) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (stor_pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      if (wr_en && !rd_en) begin
        count_d = count_q + (AWID+1)'(1);
      end else if (rd_en && !wr_en) begin
        count_d = count_q - (AWID+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 2'b00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= datain;
    end
  end

  if (OUTREG != 0) begin : gen_outreg
    logic           valid_q, valid_d;
    logic [WID-1:0] dout_q, dout_d;
    logic           stor_nempty;

    // count includes the output register, so storage holds count - valid words.
    assign stor_nempty = (count_q != {{AWID{1'b0}}, valid_q});
    assign stor_pop    = stor_nempty & (~valid_q | rd_en) & ~softreset;

    always_comb begin
      valid_d = valid_q;
      dout_d  = dout_q;
      if (softreset) begin
        valid_d = 1'b0;
      end else if (stor_pop) begin
        valid_d = 1'b1;
        dout_d  = mem_q[rptr_q];
      end else if (rd_en) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        valid_q <= valid_d;
        dout_q  <= dout_d;
      end
    end

    assign empty   = ~valid_q;
    assign dataout = dout_q;
  end else begin : gen_comb
    assign stor_pop = rd_en;
    assign empty    = (count_q == '0);
    assign dataout  = mem_q[rptr_q];
  end

endmodule

// File: doc/syncfifo_pro.md
SYNCFIFO_PRO -- requirements
Module: syncfifo_pro

Interface
REQ-001 Parameter WID, 32, data width in bits, >=1.
REQ-002 Parameter DEPTH, 8, total word capacity, >=2, need not be a power of two.
REQ-003 Parameter AWID, $clog2(DEPTH), storage pointer width.
REQ-004 Parameter OUTREG, 0, 0 = combinational read from storage, 1 = registered first-word-fall-through output stage.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 softreset  in  1  synchronous flush, active-high.
REQ-008 validin  in  1  write request.
REQ-009 datain  in  WID  write data.
REQ-010 full  out  1  no free slot.
REQ-011 readout  in  1  read/pop request.
REQ-012 dataout  out  WID  head-of-queue data.
REQ-013 empty  out  1  no word presentable on dataout.
REQ-014 count  out  AWID+1  words held, including any word in the output stage.
REQ-015 afull_th, aempty_th  in  AWID+1 each  almost-full / almost-empty thresholds, quasi-static.
REQ-016 afull, aempty  out  1 each  threshold flags.
REQ-017 overflow, underflow  out  1 each  per-cycle error pulses.
REQ-018 err_sticky  out  2  bit0 sticky overflow, bit1 sticky underflow.
REQ-019 clr_err  in  1  clears err_sticky.

Function
REQ-020 Write accepted (wr_en) iff validin && !full; read accepted (rd_en) iff readout && !empty; full and empty are sampled before the edge, so a same-cycle read never frees space for a write when full.
REQ-021 full SHALL equal (count == DEPTH).
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, power of two or not.
REQ-023 count update: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither; count SHALL never exceed DEPTH or drop below 0.
REQ-024 OUTREG=0: dataout = storage[rptr] combinationally; empty = (count == 0); a write to an empty FIFO deasserts empty on the following cycle.
REQ-025 OUTREG=1: dataout driven only from an output register with a valid bit; empty = !valid.
REQ-026 OUTREG=1: the register loads the storage head whenever storage is non-empty and the register is invalid or rd_en is asserted that cycle.
REQ-027 OUTREG=1: a write to an empty FIFO deasserts empty 2 cycles later; count rises 1 cycle after the write, so count=1 with empty=1 for exactly one cycle is legal.
REQ-028 OUTREG=1: back-to-back reads SHALL sustain one word per cycle with no bubble while count >= 2.
REQ-029 Total capacity SHALL be DEPTH in both modes; in OUTREG=1 the output register counts as one of the DEPTH slots.
REQ-030 afull = (count >= afull_th); aempty = (count <= aempty_th); both combinational from count.
REQ-031 overflow = validin && full; underflow = readout && empty; a rejected access SHALL change no state other than err_sticky.
REQ-032 err_sticky bits set on the cycle after the corresponding pulse; cleared by clr_err; a set SHALL win over clr_err in the same cycle.
REQ-033 Data order SHALL be strict FIFO, with no loss or duplication across pointer wrap.

Reset
REQ-034 On rst_n low, immediately: pointers, count, output valid and err_sticky = 0; empty=1, full=0, afull=(afull_th==0), aempty=1.
REQ-035 softreset SHALL have the same effect synchronously and SHALL take priority over same-cycle validin/readout, which are dropped without raising overflow or underflow state.
REQ-036 Storage contents SHALL NOT be reset; dataout is don't-care while empty=1.

Verification
REQ-037 DEPTH=8, OUTREG=0: write 8 words 0x1..0x8 -> full=1, count=8; 9th write -> overflow=1 that cycle, err_sticky=01 next cycle; read 8 -> 0x1..0x8 in order, then empty=1.
REQ-038 DEPTH=5, OUTREG=1: stream 20 words with continuous simultaneous read/write -> output order intact across 4 wraps, count stays bounded, no bubbles after fill.
REQ-039 OUTREG=1, empty FIFO: single write at cycle T -> count=1 at T+1, empty=0 and dataout valid at T+2.
REQ-040 Full FIFO with validin and readout asserted together -> write rejected, overflow=1, count decreases to DEPTH-1.
REQ-041 afull_th=6, aempty_th=1, DEPTH=8: fill one word per cycle -> aempty drops at count=2, afull rises at count=6; underflow on empty read sets err_sticky[1]; clr_err with simultaneous underflow -> bit stays 1.
REQ-042 rst_n pulse mid-stream, and separately softreset with validin=1 -> count=0, empty=1, err_sticky=00 on the following cycle.
